fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares the single write port of one small token FIFO between N_REQ producer actors in the dataflow (CAPH-style) datapath.
- A granted producer keeps the port for a burst of up to BURST tokens, then the grant rotates.
- Writes stop while the FIFO reports full.
- Sits between the producer actors' output channels and the FIFO's `datain`/`enw`/`full` side; the FIFO read side is untouched.

---
 rtl/fifo_wr_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the FIFO write-port round-robin arbiter.
// The stats counter widths apply only when FIFO_WR_ARB_STATS_EN is defined.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int STALL_CNT_W = 16;
    localparam int TOK_CNT_W   = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i scanning last_i+1, last_i+2, ... mod N.
// Kept standalone so read-side schedulers can reuse it.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic         found;
    int           cand;
    logic [W-1:0] cand_idx;

    always_comb begin
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= N; i++) begin
            cand     = (int'(last_i) + i) % N;
            cand_idx = W'(cand);
            if (!found && req_i[cand_idx]) begin
                idx_o = cand_idx;
                found = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one token FIFO write port between N_REQ producers, BURST tokens per grant.
// Optional FIFO_WR_ARB_STATS_EN adds stall_cnt and per-producer tok_cnt outputs.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SIZE  = 8,
    parameter int BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*SIZE-1:0]     data,
    output logic [N_REQ-1:0]          ack,
    input  logic                      fifo_full,
    output logic                      fifo_enw,
    output logic [SIZE-1:0]           fifo_datain,
    output logic [clog2(N_REQ)-1:0]   grant_id,
    output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]    stall_cnt,
    output logic [N_REQ*TOK_CNT_W-1:0] tok_cnt
`endif
);

    localparam int ID_W  = clog2(N_REQ);
    localparam int CNT_W = clog2(BURST) + 1;

    state_t            state_q;
    logic [ID_W-1:0]   owner_q;
    logic [ID_W-1:0]   last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              owner_req;
    logic              accept;

    rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // rst gates accept so nothing is written or acked in a reset cycle
    assign owner_req   = req[owner_q];
    assign accept      = rst & (state_q == GRANT) & owner_req & ~fifo_full;
    assign fifo_enw    = accept;
    assign fifo_datain = accept ? data[owner_q*SIZE +: SIZE] : '0;
    assign ack         = accept ? (N_REQ'(1) << owner_q) : '0;
    assign busy        = (state_q == GRANT);
    assign grant_id    = owner_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state_q <= IDLE;
                        last_q  <= owner_q;
                    end else if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(BURST - 1)) begin
                            state_q <= IDLE;
                            last_q  <= owner_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic stall;
    assign stall = (state_q == GRANT) & owner_req & fifo_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            tok_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (accept)
                tok_cnt[owner_q*TOK_CNT_W +: TOK_CNT_W] <= tok_cnt[owner_q*TOK_CNT_W +: TOK_CNT_W] + 1'b1;
        end
    end
`else
    // no statistics counters in this build
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a grant-session reference model.
// Stats outputs are checked only when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int S = 8;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*S-1:0] data = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   ack;
    logic           fifo_enw;
    logic [S-1:0]   fifo_datain;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]    stall_cnt;
    logic [N*16-1:0] tok_cnt;
`endif

    fifo_wr_arbiter #(.N_REQ(N), .SIZE(S), .BURST(B)) dut (
`ifdef FIFO_WR_ARB_STATS_EN
        .stall_cnt   (stall_cnt),
        .tok_cnt     (tok_cnt),
`endif
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data        (data),
        .ack         (ack),
        .fifo_full   (fifo_full),
        .fifo_enw    (fifo_enw),
        .fifo_datain (fifo_datain),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: holder = producer owning the port (-1 none), left = tokens it may still write
    int m_holder = -1;
    int m_left   = 0;
    int m_prev   = N - 1;
    int m_stalls = 0;
    int m_tok [N];

    logic           e_enw;
    logic [N-1:0]   e_ack;
    logic [S-1:0]   e_data;
    logic           e_busy;
    logic [1:0]     e_gid;

    int             cyc;
    logic [S-1:0]   log_data [$];
    int             log_gid  [$];
    int             log_cyc  [$];

    function automatic void model_outputs();
        e_enw  = 1'b0;
        e_ack  = '0;
        e_data = '0;
        e_busy = (m_holder >= 0);
        e_gid  = (m_holder >= 0) ? 2'(m_holder) : 2'b00;
        if (rst && m_holder >= 0 && req[m_holder] && !fifo_full) begin
            e_enw           = 1'b1;
            e_ack[m_holder] = 1'b1;
            e_data          = data[m_holder*S +: S];
        end
    endfunction

    function automatic void model_tick();
        int c;
        if (!rst) begin
            m_holder = -1;
            m_prev   = N - 1;
            m_stalls = 0;
            for (int i = 0; i < N; i++) m_tok[i] = 0;
            return;
        end
        if (m_holder < 0) begin
            if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_prev + k) % N;
                    if (req[c]) begin
                        m_holder = c;
                        break;
                    end
                end
                m_left = B;
            end
        end else if (!req[m_holder]) begin
            m_prev   = m_holder;
            m_holder = -1;
        end else if (fifo_full) begin
            if (m_stalls < 65535) m_stalls++;
        end else begin
            m_tok[m_holder] = (m_tok[m_holder] + 1) % 65536;
            m_left--;
            if (m_left == 0) begin
                m_prev   = m_holder;
                m_holder = -1;
            end
        end
    endfunction

    function automatic logic [15:0] dut_vec();
        return {ack, fifo_enw, fifo_datain, busy, busy ? grant_id : 2'b00};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {e_ack, e_enw, e_data, e_busy, e_busy ? e_gid : 2'b00};
    endfunction

    task automatic sample();
        @(negedge clk);
        model_outputs();
    endtask

    task automatic advance();
        if (fifo_enw) begin
            log_data.push_back(fifo_datain);
            log_gid.push_back(int'(grant_id));
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_tick();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        @(posedge clk);
        model_tick();
        #1;
        rst = 1'b1;
        cyc = 0;
        log_data.delete();
        log_gid.delete();
        log_cyc.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req       = 4'b1111;
        fifo_full = 1'b0;
        @(posedge clk);
        model_tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", busy); end
        n_checks++;
        if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got %0d required 0", grant_id); end
        n_checks++;
        if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b required 0000", ack); end
        n_checks++;
        if (fifo_enw !== 1'b0) begin n_fail++; $display("FAIL reset_enw got %b required 0", fifo_enw); end
        n_checks++;
        if (fifo_datain !== 8'h00) begin n_fail++; $display("FAIL reset_datain got %h required 00", fifo_datain); end
`ifdef FIFO_WR_ARB_STATS_EN
        n_checks++;
        if (stall_cnt !== 16'd0 || tok_cnt !== '0) begin
            n_fail++; $display("FAIL reset_stats got stall=%0d tok=%h required 0", stall_cnt, tok_cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_single();
        int  tok;
        logic acked;
        do_reset();
        tok       = 1;
        req       = 4'b0001;
        data[7:0] = 8'(tok);
        for (int c = 0; c < 11; c++) begin
            sample();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL single cyc %0d got %h required %h", cyc, dut_vec(), exp_vec());
            end
            acked = e_ack[0];
            advance();
            if (acked) begin
                tok++;
                data[7:0] = 8'(tok);
                if (tok > 8) req = '0;
            end
        end
        n_checks++;
        if (log_data.size() != 8) begin
            n_fail++; $display("FAIL single_count got %0d required 8", log_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (log_data[i] !== 8'(i + 1) || log_gid[i] != 0) begin
                    n_fail++; $display("FAIL single_write%0d got data %h id %0d required data %h id 0", i, log_data[i], log_gid[i], 8'(i + 1));
                end
            end
            n_checks++;
            if (log_cyc[4] - log_cyc[3] != 2) begin
                n_fail++; $display("FAIL single_bubble got gap %0d required 2", log_cyc[4] - log_cyc[3]);
            end
        end
    endtask

    task automatic test_all_requesting();
        int   cnt [N];
        logic [N-1:0] acked;
        do_reset();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            data[i*S +: S] = 8'(16 * i);
        end
        req = 4'b1111;
        for (int c = 0; c < 22; c++) begin
            sample();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL all_req cyc %0d got %h required %h", cyc, dut_vec(), exp_vec());
            end
            acked = e_ack;
            advance();
            for (int i = 0; i < N; i++) begin
                if (acked[i]) begin
                    cnt[i]++;
                    data[i*S +: S] = 8'(16 * i + cnt[i]);
                end
            end
        end
        req = '0;
        n_checks++;
        if (log_gid.size() != 17) begin
            n_fail++; $display("FAIL all_req_count got %0d required 17", log_gid.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                n_checks++;
                if (log_gid[i] != (i / 4) % N) begin
                    n_fail++; $display("FAIL all_req_order write %0d got id %0d required %0d", i, log_gid[i], (i / 4) % N);
                end
            end
            for (int g = 1; g < 5; g++) begin
                n_checks++;
                if (log_cyc[4*g] - log_cyc[4*g-1] != 2) begin
                    n_fail++; $display("FAIL all_req_bubble grant %0d got gap %0d required 2", g, log_cyc[4*g] - log_cyc[4*g-1]);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int   w;
        int   fc;
        logic acked;
        do_reset();
        w         = 0;
        fc        = 0;
        req       = 4'b0001;
        data[7:0] = 8'hA0;
        for (int c = 0; c < 9; c++) begin
            if (w == 2 && fc < 3) begin
                fifo_full = 1'b1;
                fc++;
            end else begin
                fifo_full = 1'b0;
            end
            sample();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL full_stall cyc %0d got %h required %h", cyc, dut_vec(), exp_vec());
            end
            if (fifo_full) begin
                n_checks++;
                if (fifo_enw !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1 || grant_id !== 2'd0) begin
                    n_fail++; $display("FAIL full_hold cyc %0d got enw %b ack %b busy %b id %0d required 0 0000 1 0", cyc, fifo_enw, ack, busy, grant_id);
                end
            end
            acked = e_ack[0];
            if (c == 8) req = '0;
            advance();
            if (acked) begin
                w++;
                data[7:0] = 8'(8'hA0 + w);
            end
        end
        n_checks++;
        if (log_data.size() != 4) begin
            n_fail++; $display("FAIL full_stall_writes got %0d required 4", log_data.size());
        end
`ifdef FIFO_WR_ARB_STATS_EN
        n_checks++;
        if (stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL stall_cnt got %0d required 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_early_release();
        logic [N-1:0] req_tab [2][5];
        req_tab[0] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
        req_tab[1] = '{4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001};
        for (int v = 0; v < 2; v++) begin
            do_reset();
            data = {8'h3B, 8'h2A, 8'h11, 8'h05};
            for (int c = 0; c < 5; c++) begin
                req = req_tab[v][c];
                sample();
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL early_rel v%0d cyc %0d got %h required %h", v, cyc, dut_vec(), exp_vec());
                end
                if (c == 2) begin
                    n_checks++;
                    if (fifo_enw !== 1'b0) begin n_fail++; $display("FAIL early_rel_nowrite got %b required 0", fifo_enw); end
                end
                if (c == 3) begin
                    n_checks++;
                    if (busy !== 1'b0) begin n_fail++; $display("FAIL early_rel_idle got %b required 0", busy); end
                end
                if (c == 4) begin
                    n_checks++;
                    if (grant_id !== (v == 0 ? 2'd3 : 2'd0)) begin
                        n_fail++; $display("FAIL early_rel_next got %0d required %0d", grant_id, (v == 0 ? 3 : 0));
                    end
                end
                advance();
            end
            req = '0;
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) rst = 1'b0;
            if (c == 3) req = 4'b0011;
            sample();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rst_mid cyc %0d got %h required %h", cyc, dut_vec(), exp_vec());
            end
            if (c == 2) begin
                n_checks++;
                if (fifo_enw !== 1'b0 || ack !== 4'b0000) begin
                    n_fail++; $display("FAIL rst_mid_write got enw %b ack %b required 0 0000", fifo_enw, ack);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b required 0", busy); end
            end
            if (c == 4) begin
                n_checks++;
                if (grant_id !== 2'd0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL rst_mid_winner got id %0d busy %b required 0 1", grant_id, busy);
                end
            end
            advance();
            rst = 1'b1;
        end
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] acked;
        do_reset();
        acked = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || acked[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    data[i*S +: S] = 8'($urandom);
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            sample();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d got %h required %h", cyc, dut_vec(), exp_vec());
            end
            acked = e_ack;
            advance();
        end
        req       = '0;
        fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== 16'(m_stalls)) begin
            n_fail++; $display("FAIL random_stall_cnt got %0d required %0d", stall_cnt, m_stalls);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (tok_cnt[i*16 +: 16] !== 16'(m_tok[i])) begin
                n_fail++; $display("FAIL random_tok_cnt%0d got %0d required %0d", i, tok_cnt[i*16 +: 16], m_tok[i]);
            end
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_tok[i] = 0;
        test_reset();
        test_single();
        test_all_requesting();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
